// File: rtl/btn_pkg.sv
// Shared types and helpers for the button-filter bank: clog2, prescaler default,
// event-kind constants and the event arbiter state type.
package btn_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned CE_DIV_DEF = 50000;

  localparam logic KIND_PRESS = 1'b0;
  localparam logic KIND_RPT   = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } arb_state_t;

endpackage

// File: rtl/btn_ce_div.sv
// Clock-enable prescaler: CE_O pulses for one cycle every CE_DIV cycles,
// the first pulse landing in cycle CE_DIV after reset release.
module btn_ce_div import btn_pkg::*; #(
  parameter int unsigned CE_DIV = CE_DIV_DEF
) (
  input  logic CLK,
  input  logic RST,
  output logic CE_O
);

  localparam int unsigned CDW = clog2(CE_DIV);

  logic [CDW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      CE_O <= 1'b0;
    end else if (cnt == CDW'(CE_DIV - 1)) begin
      cnt  <= '0;
      CE_O <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      CE_O <= 1'b0;
    end
  end

endmodule

// File: rtl/btn_event_sched.sv
// Event scheduler: shared CE tick, per-button pending flags, optional auto-repeat
// (enabled by BTN_SCHED_REPEAT_EN) and a round-robin valid/ready event channel.
module btn_event_sched import btn_pkg::*; #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned CE_DIV     = CE_DIV_DEF,
  parameter int unsigned HOLD_TICKS = 32,
  parameter int unsigned RPT_TICKS  = 8,
  localparam int unsigned CW        = (N_BTN > 1) ? clog2(N_BTN) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             CE_O,
  input  logic [N_BTN-1:0] BTN_LVL,
  input  logic [N_BTN-1:0] BTN_PRS,
  output logic             EVT_VALID,
  output logic [CW-1:0]    EVT_CODE,
  output logic             EVT_RPT,
  input  logic             EVT_READY,
  output logic             OVF
);

  logic             ce;
  logic [N_BTN-1:0] pend, kind;
  logic [N_BTN-1:0] rpt_set, rpt_clr;
  logic [N_BTN-1:0] grant_mask;
  logic [CW-1:0]    ptr, grant_idx;
  logic             grant_ok, take;
  logic             evt_rpt_q;
  arb_state_t       state, state_n;

  btn_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
    .CLK  (CLK),
    .RST  (RST),
    .CE_O (ce)
  );

  assign CE_O = ce;

`ifdef BTN_SCHED_REPEAT_EN
  localparam int unsigned RMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int unsigned RW   = clog2(RMAX + 1);

  logic [RW-1:0]    rcnt [N_BTN];
  logic [N_BTN-1:0] first_done, rpt_req, lvl_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < N_BTN; i++) rcnt[i] <= '0;
      first_done <= '0;
      rpt_req    <= '0;
      lvl_q      <= '0;
    end else begin
      rpt_req <= '0;
      lvl_q   <= BTN_LVL;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (!BTN_LVL[i] || BTN_PRS[i]) begin
          rcnt[i]       <= '0;
          first_done[i] <= 1'b0;
        end else if (ce) begin
          if (rcnt[i] + 1'b1 == (first_done[i] ? RW'(RPT_TICKS) : RW'(HOLD_TICKS))) begin
            rcnt[i]       <= '0;
            first_done[i] <= 1'b1;
            rpt_req[i]    <= 1'b1;
          end else begin
            rcnt[i] <= rcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // A request registered just as the button was released must not become an event.
  assign rpt_set = rpt_req & BTN_LVL;
  assign rpt_clr = lvl_q & ~BTN_LVL;
  assign EVT_RPT = evt_rpt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{BTN_LVL, 32'(HOLD_TICKS), 32'(RPT_TICKS), evt_rpt_q};
  assign rpt_set    = '0;
  assign rpt_clr    = '0;
  assign EVT_RPT    = 1'b0;
`endif

  // Round-robin search: walk offsets from the far end so the nearest hit to PTR wins.
  always_comb begin
    int unsigned idx;
    logic [CW-1:0] idx_c;
    grant_ok  = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_c     = '0;
    for (int unsigned off = N_BTN; off > 0; off--) begin
      idx = 32'(ptr) + off - 1;
      if (idx >= N_BTN) idx = idx - N_BTN;
      idx_c = CW'(idx);
      if (pend[idx_c]) begin
        grant_ok  = 1'b1;
        grant_idx = idx_c;
      end
    end
  end

  always_comb begin
    state_n    = state;
    take       = 1'b0;
    grant_mask = '0;
    case (state)
      ST_IDLE: begin
        if (grant_ok) begin
          state_n               = ST_PRESENT;
          take                  = 1'b1;
          grant_mask[grant_idx] = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (EVT_READY) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EVT_VALID <= 1'b0;
      EVT_CODE  <= '0;
      evt_rpt_q <= 1'b0;
      ptr       <= '0;
    end else if (take) begin
      EVT_VALID <= 1'b1;
      EVT_CODE  <= grant_idx;
      evt_rpt_q <= kind[grant_idx];
    end else if (state == ST_PRESENT && EVT_READY) begin
      EVT_VALID <= 1'b0;
      ptr       <= (EVT_CODE == CW'(N_BTN - 1)) ? '0 : EVT_CODE + 1'b1;
    end
  end

  // Later assignments take priority, so a new set beats a same-cycle grant clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend <= '0;
      kind <= '0;
      OVF  <= 1'b0;
    end else begin
      OVF <= |(BTN_PRS & pend & ~kind & ~grant_mask);
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (grant_mask[i] || (rpt_clr[i] && pend[i] && kind[i] == KIND_RPT))
          pend[i] <= 1'b0;
        if (BTN_PRS[i]) begin
          pend[i] <= 1'b1;
          kind[i] <= KIND_PRESS;
        end else if (rpt_set[i] && !pend[i]) begin
          pend[i] <= 1'b1;
          kind[i] <= KIND_RPT;
        end
      end
    end
  end

endmodule

// File: doc/btn_event_sched.md
# btn_event_sched

Event scheduler for the button-filter bank. It generates the shared clock-enable tick that every filter instance uses, and collects the filters' stable levels and one-cycle press strobes. Presses and (optionally) auto-repeats are arbitrated round-robin onto a single valid/ready event channel consumed by the control FSM.

## Interface
- N_BTN, 4, number of filtered buttons (1..16)
- CE_DIV, 50000, CLK cycles per CE tick (>= 2)
- HOLD_TICKS, 32, CE ticks a button must stay held before the first repeat (>= 1)
- RPT_TICKS, 8, CE ticks between subsequent repeats (>= 1)

Ports (reset RST, asynchronous, active-high; clock CLK):
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- CE_O  out  1  one-cycle tick every CE_DIV cycles, fanned out to all filter CE inputs
- BTN_LVL  in  N_BTN  stable filtered level per button
- BTN_PRS  in  N_BTN  one-cycle press strobe per button
- EVT_VALID  out  1  event available
- EVT_CODE  out  CW = max(1, clog2(N_BTN))  index of the button
- EVT_RPT  out  1  0 = press event, 1 = auto-repeat event
- EVT_READY  in  1  consumer accepts the event
- OVF  out  1  one-cycle pulse: a press was dropped

## Operation
- Prescaler:
  - Counter counts 0..CE_DIV-1 and wraps to 0.
  - CE_O is registered and high for the one cycle after the counter reaches CE_DIV-1.
  - First CE_O occurs in cycle CE_DIV after reset release.
- Pending flags, per button i:
  - Each button has PEND[i] and KIND[i] (0 press, 1 repeat).
  - BTN_PRS[i] sets PEND[i] and KIND[i]=0.
  - A press while PEND[i]=1 and KIND[i]=0, not being granted that cycle, is dropped and OVF pulses on the next cycle.
  - A press overrides a pending repeat (KIND becomes 0, no OVF).
  - A repeat request while PEND[i]=1 is dropped silently.
  - A set and a grant-clear of the same bit in the same cycle: the set wins.
- Repeat counter, per button:
  - Width clog2(max(HOLD_TICKS, RPT_TICKS)+1).
  - Cleared while BTN_LVL[i]=0 and on BTN_PRS[i]; otherwise it increments on CE_O.
  - Reaching HOLD_TICKS (first repeat) or RPT_TICKS (later repeats) raises a repeat request, and the counter restarts at 0.
  - A falling BTN_LVL[i] clears a pending repeat (not a pending press).
- Arbiter FSM:
  - IDLE: if any PEND bit is set, grant the first set bit at or after the round-robin pointer PTR (modulo N_BTN). Load EVT_CODE and EVT_RPT, set EVT_VALID, clear that PEND bit, go to PRESENT.
  - PRESENT: EVT_CODE and EVT_RPT stay stable and EVT_VALID stays high until EVT_VALID & EVT_READY. On acceptance, PTR = grant+1 (wrapping N_BTN-1 -> 0), EVT_VALID drops, go to IDLE.
  - EVT_READY is ignored while EVT_VALID=0.
- Reset values: all counters, PEND, KIND, PTR = 0; CE_O, EVT_VALID, EVT_RPT, OVF = 0; EVT_CODE = 0; FSM = IDLE. Reset mid-handshake drops EVT_VALID immediately, and the in-flight event is lost.

## Timing
- Press latency: BTN_PRS in cycle t gives PEND in t+1 and EVT_VALID in t+2 (FSM idle).
- Throughput: one event per 2 cycles at EVT_READY=1, because IDLE is one bubble cycle.
- The repeat request is registered one cycle after the qualifying CE_O; the event follows two cycles later.
- OVF lags the dropped strobe by 1 cycle.

## Configuration
- Macro BTN_SCHED_REPEAT_EN.
  - Defined: repeat counters and repeat requests are built as described.
  - Undefined: no repeat logic, and EVT_RPT is tied to 0. HOLD_TICKS and RPT_TICKS are unused. Only presses generate events.

## Structure
- Shared package btn_pkg:
  - Function clog2.
  - Localparam default for CE_DIV.
  - Event-kind constants KIND_PRESS=0, KIND_RPT=1.
  - FSM state encodings ST_IDLE and ST_PRESENT.
- Sub-module btn_ce_div holds the prescaler (CLK, RST, CE_O; parameter CE_DIV), so it is reusable by other tick consumers.

## Test plan
- Reset release, CE_DIV=4 -> CE_O high in cycles 4, 8, 12; no other CE_O pulses.
- BTN_PRS[2] single pulse at t, EVT_READY=1 -> EVT_VALID at t+2 with EVT_CODE=2, EVT_RPT=0; accepted the same cycle, low at t+3.
- BTN_PRS=4'b1011 in one cycle, PTR=0, EVT_READY=1 -> events in code order 0, 1, 3, each 2 cycles apart; then PTR=0.
- EVT_READY=0 while pending, then a second BTN_PRS[1] while PEND[1] is set -> OVF pulse; EVT_CODE stable; only one code-1 event after READY.
- BTN_LVL[0] held, HOLD_TICKS=3, RPT_TICKS=2, CE_DIV=4 -> repeat events (EVT_RPT=1) after the 3rd CE_O, then every 2nd CE_O; stop on release.
- RST asserted while EVT_VALID=1 -> EVT_VALID and CE_O low immediately; no event after release without new strobes.
